led_pattern_sink: RTL and testbench
===================================

# led_pattern_sink

Parametrised valid/ready sink that drives an N-bit LED bank from a stream of pattern commands. Commands are buffered in an internal FIFO. Each command is shown for a fixed number of slow ticks in one of four display modes. A built-in prescaler makes the ticks, so the block needs no divided clock and runs entirely in the `clk` domain. It replaces the fixed 4-LED slave plus external divider arrangement as the endpoint of the fabric handshake chain.

## Interface
Parameters:
- `NUM_LEDS`, 4: LED count, ≥2
- `FIFO_DEPTH`, 4: command FIFO entries, power of two, ≥2
- `CLK_DIV`, 50_000_000: `clk` cycles per tick, ≥2
- `DWELL_TICKS`, 2: ticks each command is displayed, ≥1

Ports:
- `clk`  in  1: single clock, rising edge
- `rst`  in  1: synchronous, active-high reset
- `in_valid`  in  1: command valid
- `in_ready`  out  1: FIFO can accept
- `in_data`  in  NUM_LEDS+2: `[NUM_LEDS+1:NUM_LEDS]` mode, `[NUM_LEDS-1:0]` pattern
- `led`  out  NUM_LEDS: registered LED drive
- `busy`  out  1: high in SHOW
- `fifo_level`  out  clog2(FIFO_DEPTH)+1: registered entry count

## Operation
- **Handshake:**
  - Transfer happens on a rising edge with `in_valid && in_ready`.
  - `in_ready = (fifo_level != FIFO_DEPTH)`, derived from the registered count only. A pop in the same cycle never re-opens `in_ready`.
  - `in_valid` while not ready: data is ignored, no error.
- **FIFO:**
  - Circular buffer with wrap-around pointers.
  - A simultaneous push and pop leaves `fifo_level` unchanged.
- **FSM states:** IDLE, SHOW.
  - IDLE, `fifo_level != 0`: pop the head, load the display registers, go to SHOW.
  - IDLE, FIFO empty: `led` holds its last value.
  - SHOW: the prescaler counts 0..CLK_DIV-1. `tick` is asserted when prescale == CLK_DIV-1, after which prescale wraps to 0.
  - On each tick, `phase` increments (0..DWELL_TICKS-1) and `rot` increments modulo NUM_LEDS.
  - Tick with `phase == DWELL_TICKS-1` and FIFO non-empty: pop and load the next command in the same cycle and stay in SHOW. There is no gap cycle.
  - Tick with `phase == DWELL_TICKS-1` and FIFO empty: go to IDLE; `led` holds.
- **Load:** `prescale`, `phase` and `rot` are set to 0, and `led` takes the mode's phase-0 value.
- **Modes:** the `led` value is recomputed on each tick.
  - 00 static: `led = pattern`.
  - 01 blink: `led = pattern` when `phase` is even, 0 when odd.
  - 10 rotate-left: `led = pattern` rotated left by `rot`.
  - 11 rotate-right: `led = pattern` rotated right by `rot`.
- **Reset:**
  - While `rst` is high: `led`=0, `fifo_level`=0, `busy`=0, `in_ready`=0, state IDLE, all pointers and counters 0. FIFO contents are discarded.
  - Reset mid-SHOW aborts the current command immediately.
  - `in_ready` rises the cycle after `rst` falls.

## Timing
- **Push to LED:**
  - A push at edge N into an empty FIFO with the FSM in IDLE gives `fifo_level`=1 after N.
  - The FSM pops at edge N+1, so `led` and `busy` are valid after N+1 (2-cycle latency).
- **Dwell:** each command occupies exactly CLK_DIV*DWELL_TICKS cycles from its load edge to the next load edge or the IDLE transition.
- **Blink/rotate step:** `led` changes on the edge where `tick` is asserted, i.e. every CLK_DIV cycles after load.
- **SHOW to IDLE:** `busy` falls on the final tick edge.
- **Throughput:** back-to-back commands need no idle cycle between dwells.

## Test plan
Bench parameters: NUM_LEDS=4, FIFO_DEPTH=4, CLK_DIV=4, DWELL_TICKS=3 (dwell = 12 cycles).
- **Reset values:** hold `rst` 3 cycles → `led`=0000, `in_ready`=0, `busy`=0. Release → `in_ready`=1 next cycle.
- **Static latency/dwell:** push {00,1010} at edge N → `led`=1010 after N+1. `busy` stays high for 12 cycles, then IDLE with `led` held at 1010.
- **Blink and rotate:**
  - Push {01,1111} → `led` 1111, 0000, 1111 at 4-cycle spacing.
  - Then push {10,0001} → 0001, 0010, 0100.
  - Then push {11,0001} → 0001, 1000, 0100.
- **Full FIFO/backpressure:** hold `in_valid` high with distinct patterns while SHOW is busy → `in_ready` falls when `fifo_level`=4. Extra words are not stored. All 5 accepted commands display in order, each for 12 cycles with no gaps.
- **Simultaneous push/pop:** push on the exact dwell-end edge with `fifo_level`=1 → level stays 1 and the next command loads on that edge.
- **Reset mid-operation:** assert `rst` 5 cycles into a rotate command with 2 entries queued → `led`=0000, `fifo_level`=0. No stale command displays after release.

Source files
------------

// File: rtl/led_pattern_sink.sv
// led_pattern_sink: valid/ready command sink that drives an LED bank.
// Commands {mode, pattern} queue in a small circular FIFO. Each one is shown
// for DWELL_TICKS slow ticks made by an internal prescaler, so everything
// runs in the single clk domain.

// One LED lane: picks this lane's bit of the pattern for the given mode,
// rotation amount and blink phase.
module ledPatternLane #(
  parameter int NUM_LEDS = 4,
  parameter int LANE     = 0,
  parameter int RW       = 2
) (
  input  logic [NUM_LEDS-1:0] pattern,
  input  logic [1:0]          mode,
  input  logic [RW-1:0]       rot,
  input  logic                phaseOdd,
  output logic                ledBit
);

  int          rotI;
  int          lIdx;
  int          rIdx;
  logic [RW-1:0] lSel;
  logic [RW-1:0] rSel;

  // Source bit for rotate-left is lane-rot, for rotate-right lane+rot (mod N).
  always_comb begin
    rotI   = int'(rot);
    lIdx   = (LANE + NUM_LEDS - rotI) % NUM_LEDS;
    rIdx   = (LANE + rotI) % NUM_LEDS;
    lSel   = lIdx[RW-1:0];
    rSel   = rIdx[RW-1:0];
    ledBit = pattern[LANE];
    case (mode)
      2'b00:   ledBit = pattern[LANE];
      2'b01:   ledBit = pattern[LANE] & ~phaseOdd;
      2'b10:   ledBit = pattern[lSel];
      default: ledBit = pattern[rSel];
    endcase
  end

endmodule

module led_pattern_sink #(
  parameter int NUM_LEDS    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CLK_DIV     = 50_000_000,
  parameter int DWELL_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LEDS+1:0]         in_data,
  output logic [NUM_LEDS-1:0]         led,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = $clog2(CLK_DIV);
  localparam int PHW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int RW  = $clog2(NUM_LEDS);

  typedef struct packed {
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] pattern;
  } cmd_t;

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state, stateNext;
  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head, cur, selCmd;
  logic [AW-1:0] wrPtr, rdPtr;
  logic          readyEn;
  logic          push, pop;

  logic [PW-1:0]       prescale;
  logic [PHW-1:0]      phase, phaseInc;
  logic [RW-1:0]       rot, rotInc, selRot;
  logic                selOdd;
  logic                tick, lastTick;
  logic [NUM_LEDS-1:0] ledNext;

  // readyEn keeps in_ready low through reset and for the first edge after it.
  assign in_ready = readyEn && !rst && (fifo_level != (AW+1)'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem[rdPtr];
  assign busy     = (state == SHOW);

  // FIFO storage; contents need no reset since the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= cmd_t'(in_data);
  end

  // FIFO pointers, occupancy and the post-reset ready enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_level <= '0;
      readyEn    <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  assign tick     = (state == SHOW) && (prescale == PW'(CLK_DIV - 1));
  assign lastTick = tick && (phase == PHW'(DWELL_TICKS - 1));
  assign phaseInc = phase + 1'b1;
  assign rotInc   = (rot == RW'(NUM_LEDS - 1)) ? '0 : rot + 1'b1;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state and pop: load from IDLE or chain straight into the next dwell.
  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_level != '0) begin
          pop       = 1'b1;
          stateNext = SHOW;
        end
      end
      SHOW: begin
        if (lastTick) begin
          if (fifo_level != '0) pop = 1'b1;
          else                  stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // A load shows the head at phase 0 / rot 0; a tick shows the current
  // command at the incremented phase and rotation.
  always_comb begin
    selCmd = cur;
    selRot = rotInc;
    selOdd = phaseInc[0];
    if (pop) begin
      selCmd = head;
      selRot = '0;
      selOdd = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gLane
    ledPatternLane #(.NUM_LEDS(NUM_LEDS), .LANE(i), .RW(RW)) uLane (
      .pattern  (selCmd.pattern),
      .mode     (selCmd.mode),
      .rot      (selRot),
      .phaseOdd (selOdd),
      .ledBit   (ledNext[i])
    );
  end

  // Display datapath: prescaler, dwell phase, rotation and LED register.
  // On the final tick without a follow-on command the LEDs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      prescale <= '0;
      phase    <= '0;
      rot      <= '0;
      led      <= '0;
    end else if (pop) begin
      cur      <= head;
      prescale <= '0;
      phase    <= '0;
      rot      <= '0;
      led      <= ledNext;
    end else if (state == SHOW) begin
      if (tick) begin
        prescale <= '0;
        if (lastTick) begin
          phase <= '0;
          rot   <= '0;
        end else begin
          phase <= phaseInc;
          rot   <= rotInc;
          led   <= ledNext;
        end
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sink.sv
// Bench for led_pattern_sink (4 LEDs, 4-deep FIFO, 4-cycle tick, 3-tick dwell).
// Expected observations are queued with the edge number they belong to and
// checked at the following negedge.
module tb_led_pattern_sink;

  localparam int K_LED = 0, K_BUSY = 1, K_LVL = 2, K_RDY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [3:0] led;
  logic       busy;
  logic [2:0] fifo_level;

  int cyc = 0;
  int nCmp = 0;
  int nBad = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [3:0] val;
    string      nm;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] pat;
    logic [3:0] e0, e1, e2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];

  led_pattern_sink #(.NUM_LEDS(4), .FIFO_DEPTH(4), .CLK_DIV(4), .DWELL_TICKS(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .led(led), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare every expectation due at this edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [3:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_LED:   act = led;
        K_BUSY:  act = {3'b0, busy};
        K_LVL:   act = {1'b0, fifo_level};
        default: act = {3'b0, in_ready};
      endcase
      nCmp++;
      if (e.cyc != cyc || act !== e.val) begin
        nBad++;
        $display("FAIL %s @edge %0d: got %b, expected %b (due edge %0d)", e.nm, cyc, act, e.val, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic expect_(input int c, input int k, input logic [3:0] v, input string nm);
    exp_t e;
    int i;
    e.cyc = c; e.kind = k; e.val = v; e.nm = nm;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  initial begin
    int n, a, b, c, guard;
    logic [3:0] prevLed;

    vecs[0] = '{2'b00, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
    vecs[1] = '{2'b01, 4'b1111, 4'b1111, 4'b0000, 4'b1111};
    vecs[2] = '{2'b10, 4'b0001, 4'b0001, 4'b0010, 4'b0100};
    vecs[3] = '{2'b11, 4'b0001, 4'b0001, 4'b1000, 4'b0100};
    vecs[4] = '{2'b10, 4'b1001, 4'b1001, 4'b0011, 4'b0110};
    vecs[5] = '{2'b11, 4'b0110, 4'b0110, 4'b0011, 4'b1001};
    vecs[6] = '{2'b01, 4'b0101, 4'b0101, 4'b0000, 4'b0101};

    // Reset held for three edges.
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) step();
    expect_(3, K_LED,  4'd0, "rst_led");
    expect_(3, K_BUSY, 4'd0, "rst_busy");
    expect_(3, K_LVL,  4'd0, "rst_level");
    expect_(3, K_RDY,  4'd0, "rst_ready_low_after_release");
    expect_(4, K_RDY,  4'd1, "ready_rises_next_cycle");
    rst = 1'b0;
    step();

    // Table-driven single commands from IDLE: latency, mode steps, dwell, hold.
    prevLed = 4'd0;
    for (int i = 0; i < 7; i++) begin
      n = cyc + 1;
      expect_(n,      K_LVL,  4'd1,       "vec_level_after_push");
      expect_(n,      K_RDY,  4'd1,       "vec_ready");
      expect_(n,      K_LED,  prevLed,    "vec_idle_hold");
      expect_(n,      K_BUSY, 4'd0,       "vec_busy_before_load");
      expect_(n + 1,  K_LED,  vecs[i].e0, "vec_led_phase0");
      expect_(n + 1,  K_BUSY, 4'd1,       "vec_busy_on_load");
      expect_(n + 1,  K_LVL,  4'd0,       "vec_level_after_pop");
      expect_(n + 4,  K_LED,  vecs[i].e0, "vec_led_phase0_end");
      expect_(n + 5,  K_LED,  vecs[i].e1, "vec_led_phase1");
      expect_(n + 8,  K_LED,  vecs[i].e1, "vec_led_phase1_end");
      expect_(n + 9,  K_LED,  vecs[i].e2, "vec_led_phase2");
      expect_(n + 12, K_BUSY, 4'd1,       "vec_busy_last_cycle");
      expect_(n + 13, K_BUSY, 4'd0,       "vec_busy_falls");
      expect_(n + 13, K_LED,  vecs[i].e2, "vec_led_held_at_idle");
      expect_(n + 15, K_LED,  vecs[i].e2, "vec_led_still_held");
      in_valid = 1'b1;
      in_data  = {vecs[i].mode, vecs[i].pat};
      step();
      in_valid = 1'b0;
      waitCyc(n + 15);
      prevLed = vecs[i].e2;
    end

    // Backpressure: in_valid held high while busy; five words fit.
    a = cyc + 1;
    expect_(a,      K_LVL, 4'd1, "bp_level_a0");
    expect_(a + 1,  K_LVL, 4'd1, "bp_level_push_pop");
    expect_(a + 2,  K_LVL, 4'd2, "bp_level_2");
    expect_(a + 3,  K_LVL, 4'd3, "bp_level_3");
    expect_(a + 3,  K_RDY, 4'd1, "bp_ready_at_3");
    expect_(a + 4,  K_LVL, 4'd4, "bp_level_full");
    expect_(a + 4,  K_RDY, 4'd0, "bp_ready_falls_full");
    expect_(a + 12, K_RDY, 4'd0, "bp_ready_low_before_pop");
    expect_(a + 12, K_LVL, 4'd4, "bp_extra_not_stored");
    expect_(a + 13, K_LVL, 4'd3, "bp_level_after_pop");
    expect_(a + 13, K_RDY, 4'd1, "bp_ready_reopens");
    expect_(a + 25, K_LVL, 4'd2, "bp_level_2_left");
    expect_(a + 37, K_LVL, 4'd1, "bp_level_1_left");
    expect_(a + 49, K_LVL, 4'd0, "bp_level_empty");
    for (int k = 0; k < 5; k++) begin
      expect_(a + 1 + 12 * k,  K_LED,  4'(k + 1), "bp_order_start");
      expect_(a + 12 + 12 * k, K_LED,  4'(k + 1), "bp_order_end");
      expect_(a + 12 + 12 * k, K_BUSY, 4'd1,      "bp_no_gap");
    end
    expect_(a + 61, K_BUSY, 4'd0, "bp_idle_after_five");
    expect_(a + 61, K_LED,  4'd5, "bp_last_held");
    for (int k = 0; k < 14; k++) begin
      in_valid = 1'b1;
      in_data  = {2'b00, 4'(k + 1)};
      step();
    end
    in_valid = 1'b0;
    waitCyc(a + 64);

    // Push landing exactly on the dwell-end edge while one entry is queued.
    b = cyc + 1;
    expect_(b,      K_LVL,  4'd1,    "pp_level_x");
    expect_(b + 1,  K_LVL,  4'd0,    "pp_level_x_loaded");
    expect_(b + 2,  K_LVL,  4'd1,    "pp_level_y");
    expect_(b + 12, K_LED,  4'b0100, "pp_x_last");
    expect_(b + 13, K_LVL,  4'd1,    "pp_level_unchanged");
    expect_(b + 13, K_LED,  4'b1100, "pp_y_loads_on_edge");
    expect_(b + 13, K_BUSY, 4'd1,    "pp_busy_kept");
    expect_(b + 17, K_LED,  4'b0000, "pp_y_blink_off");
    expect_(b + 25, K_LED,  4'b0111, "pp_z_loads");
    expect_(b + 25, K_LVL,  4'd0,    "pp_level_z_popped");
    expect_(b + 37, K_BUSY, 4'd0,    "pp_idle");
    expect_(b + 37, K_LED,  4'b0111, "pp_z_held");
    in_valid = 1'b1; in_data = {2'b10, 4'b0001};
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_data = {2'b01, 4'b1100};
    step();
    in_valid = 1'b0;
    waitCyc(b + 12);
    in_valid = 1'b1; in_data = {2'b00, 4'b0111};
    step();
    in_valid = 1'b0;
    waitCyc(b + 40);

    // Reset five cycles into a rotate with two commands queued.
    c = cyc + 1;
    expect_(c + 5,  K_LED,  4'b0110, "rs_rot_before_reset");
    expect_(c + 5,  K_LVL,  4'd2,    "rs_two_queued");
    expect_(c + 5,  K_RDY,  4'd0,    "rs_ready_low_in_reset");
    expect_(c + 6,  K_LED,  4'd0,    "rs_led_cleared");
    expect_(c + 6,  K_LVL,  4'd0,    "rs_level_cleared");
    expect_(c + 6,  K_BUSY, 4'd0,    "rs_busy_cleared");
    expect_(c + 7,  K_RDY,  4'd1,    "rs_ready_back");
    expect_(c + 10, K_LED,  4'd0,    "rs_no_stale_led");
    expect_(c + 10, K_BUSY, 4'd0,    "rs_no_stale_busy");
    expect_(c + 20, K_LED,  4'd0,    "rs_no_stale_led_late");
    expect_(c + 20, K_LVL,  4'd0,    "rs_level_stays_0");
    in_valid = 1'b1; in_data = {2'b10, 4'b0011};
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_data = {2'b00, 4'b1111};
    step();
    in_data = {2'b00, 4'b1110};
    step();
    in_valid = 1'b0;
    waitCyc(c + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    waitCyc(c + 20);

    // Let any remaining expectations come due, bounded.
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      step();
      guard++;
    end
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      nCmp++;
      nBad++;
      $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
